// File: rtl/braun_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial Braun multiplier sequencer.
package braun_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int unsigned DIGIT_W = 4;

   function automatic int unsigned num_digits(input int unsigned width);
      return width / DIGIT_W;
   endfunction

   function automatic int unsigned num_steps(input int unsigned width);
      return num_digits(width) * num_digits(width);
   endfunction

endpackage

// File: rtl/braun_mult_sequencer_if.sv
// Operand/result valid-ready bus of the multiplier sequencer; master is the operand source and result sink.
interface braun_mult_sequencer_if #(parameter int unsigned WIDTH = 8) ();

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_p;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p
   );

endinterface

// File: rtl/Braun_Multiplier.sv
// Combinational 4x4 unsigned Braun array: carry-save rows of full adders plus a final ripple row.
module Braun_Multiplier (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [3:0] s [4];
   logic [3:0] c [4];
   logic [4:0] se;
   logic [3:0] rc;
   logic       x, y, z;

   always_comb begin
      p  = '0;
      rc = '0;
      se = '0;
      x  = 1'b0;
      y  = 1'b0;
      z  = 1'b0;
      for (int unsigned r = 0; r < 4; r++) begin
         s[r] = '0;
         c[r] = '0;
      end

      for (int unsigned k = 0; k < 4; k++) begin
         s[0][k] = a[k] & b[0];
      end
      p[0] = s[0][0];

      // Row r adds a&b[r] to the previous row's sum (shifted down one) and carries.
      for (int unsigned r = 1; r < 4; r++) begin
         se = {1'b0, s[r-1]};
         for (int unsigned k = 0; k < 4; k++) begin
            x = a[k] & b[r];
            y = se[k+1];
            z = c[r-1][k];
            s[r][k] = x ^ y ^ z;
            c[r][k] = (x & y) | (x & z) | (y & z);
         end
         p[r] = s[r][0];
      end

      se = {1'b0, s[3]};
      for (int unsigned k = 0; k < 3; k++) begin
         y = se[k+1];
         z = c[3][k];
         p[4+k]  = y ^ z ^ rc[k];
         rc[k+1] = (y & z) | (y & rc[k]) | (z & rc[k]);
      end
      p[7] = c[3][3] ^ rc[3];
   end

endmodule

// File: rtl/braun_mult_sequencer.sv
// WIDTH x WIDTH unsigned multiplier that issues one 4x4 digit product per cycle to a shared Braun array
// and shift-accumulates the partial products into a 2*WIDTH result.
module braun_mult_sequencer
   import braun_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   braun_mult_sequencer_if.slave bus,
   output logic                 busy
);

   localparam int unsigned N  = num_digits(WIDTH);
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
         $error("braun_mult_sequencer: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   state_t             state;
   logic [WIDTH-1:0]   op_a, op_b;
   logic [CW-1:0]      i, j;
   logic [2*WIDTH-1:0] acc, acc_next, pp_shift, out_p_r;
   logic [DIGIT_W-1:0] da, db;
   logic [7:0]         pp;
   logic               in_ready_r, out_valid_r, busy_r;

   always_comb begin
      da = '0;
      db = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (i == CW'(k)) da = op_a[k*DIGIT_W +: DIGIT_W];
         if (j == CW'(k)) db = op_b[k*DIGIT_W +: DIGIT_W];
      end
   end

   Braun_Multiplier u_array (
      .a (da),
      .b (db),
      .p (pp)
   );

   always_comb begin
      pp_shift = (2*WIDTH)'(pp) << (DIGIT_W * (32'(i) + 32'(j)));
      acc_next = acc + pp_shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_p_r     <= '0;
         busy_r      <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         i           <= '0;
         j           <= '0;
         acc         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               in_ready_r <= 1'b1;
               if (bus.in_valid && in_ready_r) begin
                  op_a       <= bus.in_a;
                  op_b       <= bus.in_b;
                  i          <= '0;
                  j          <= '0;
                  acc        <= '0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (j == LAST) begin
                  j <= '0;
                  if (i == LAST) begin
                     i           <= '0;
                     out_p_r     <= acc_next;
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     i <= i + CW'(1);
                  end
               end else begin
                  j <= j + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_p     = out_p_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_braun_mult_sequencer.sv
// Scoreboard bench for braun_mult_sequencer at WIDTH 4, 8 and 16 running side by side.
module tb_braun_mult_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4, rst8, rst16;
   logic busy4, busy8, busy16;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   braun_mult_sequencer_if #(.WIDTH(4))  i4  ();
   braun_mult_sequencer_if #(.WIDTH(8))  i8  ();
   braun_mult_sequencer_if #(.WIDTH(16)) i16 ();

   braun_mult_sequencer #(.WIDTH(4))  u4  (.clk(clk), .rst(rst4),  .bus(i4),  .busy(busy4));
   braun_mult_sequencer #(.WIDTH(8))  u8  (.clk(clk), .rst(rst8),  .bus(i8),  .busy(busy8));
   braun_mult_sequencer #(.WIDTH(16)) u16 (.clk(clk), .rst(rst16), .bus(i16), .busy(busy16));

   logic [31:0] q4[$], q8[$], q16[$];
   int acc4 = 0, acc8 = 0, acc16 = 0;
   bit pv4 = 0, pv8 = 0, pv16 = 0;
   bit done16 = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitors: accept timestamp, latency on out_valid rise, scoreboard pop on handshake.
   always @(negedge clk) begin
      if (rst4) begin
         q4.delete(); pv4 = 0;
      end else begin
         if (i4.in_valid && i4.in_ready) acc4 = cyc + 1;
         if (i4.out_valid && !pv4) check("w4_latency", 64'(cyc - acc4), 64'd1);
         if (i4.out_valid && i4.out_ready) begin
            if (q4.size() == 0) check("w4_spurious", 64'd1, 64'd0);
            else check("w4_product", 64'(i4.out_p), 64'(q4.pop_front()));
         end
         pv4 = i4.out_valid;
      end
   end

   always @(negedge clk) begin
      if (rst8) begin
         q8.delete(); pv8 = 0;
      end else begin
         if (i8.in_valid && i8.in_ready) acc8 = cyc + 1;
         if (i8.out_valid && !pv8) check("w8_latency", 64'(cyc - acc8), 64'd4);
         if (i8.out_valid && i8.out_ready) begin
            if (q8.size() == 0) check("w8_spurious", 64'd1, 64'd0);
            else check("w8_product", 64'(i8.out_p), 64'(q8.pop_front()));
         end
         pv8 = i8.out_valid;
      end
   end

   always @(negedge clk) begin
      if (rst16) begin
         q16.delete(); pv16 = 0;
      end else begin
         if (i16.in_valid && i16.in_ready) acc16 = cyc + 1;
         if (i16.out_valid && !pv16) check("w16_latency", 64'(cyc - acc16), 64'd16);
         if (i16.out_valid && i16.out_ready) begin
            if (q16.size() == 0) check("w16_spurious", 64'd1, 64'd0);
            else check("w16_product", 64'(i16.out_p), 64'(q16.pop_front()));
         end
         pv16 = i16.out_valid;
      end
   end

   task automatic send4(input logic [3:0] a, input logic [3:0] b);
      int unsigned t = 0;
      i4.in_a = a; i4.in_b = b; i4.in_valid = 1'b1;
      q4.push_back(32'(a) * 32'(b));
      while (!i4.in_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) check("w4_accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      i4.in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit push);
      int unsigned t = 0;
      i8.in_a = a; i8.in_b = b; i8.in_valid = 1'b1;
      if (push) q8.push_back(32'(a) * 32'(b));
      while (!i8.in_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) check("w8_accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      i8.in_valid = 1'b0;
   endtask

   task automatic send16(input logic [15:0] a, input logic [15:0] b);
      int unsigned t = 0;
      i16.in_a = a; i16.in_b = b; i16.in_valid = 1'b1;
      q16.push_back(32'(a) * 32'(b));
      while (!i16.in_ready && t < 500) begin @(posedge clk); #1; t++; end
      if (t >= 500) check("w16_accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      i16.in_valid = 1'b0;
   endtask

   task automatic drain4;
      int unsigned t = 0;
      while (q4.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
      if (q4.size() != 0) check("w4_drain", 64'(q4.size()), 64'd0);
   endtask

   task automatic drain8;
      int unsigned t = 0;
      while (q8.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
      if (q8.size() != 0) check("w8_drain", 64'(q8.size()), 64'd0);
   endtask

   task automatic drain16;
      int unsigned t = 0;
      while (q16.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
      if (q16.size() != 0) check("w16_drain", 64'(q16.size()), 64'd0);
   endtask

   task automatic phase8;
      logic [31:0] exp;
      int unsigned t;
      i8.in_valid = 1'b0; i8.in_a = '0; i8.in_b = '0; i8.out_ready = 1'b0;
      rst8 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("w8_rst_out_valid", 64'(i8.out_valid), 64'd0);
         check("w8_rst_out_p", 64'(i8.out_p), 64'd0);
         check("w8_rst_busy", 64'(busy8), 64'd0);
      end
      rst8 = 1'b0;
      @(posedge clk); #1;
      check("w8_in_ready_after_rst", 64'(i8.in_ready), 64'd1);

      i8.out_ready = 1'b1;
      send8(8'hFF, 8'hFF, 1'b1);
      drain8();
      send8(8'h12, 8'h34, 1'b1);
      send8(8'h00, 8'hA5, 1'b1);
      drain8();

      // Backpressure: result held while the sink stalls, new offers ignored.
      i8.out_ready = 1'b0;
      exp = 32'h1518;
      send8(8'h5A, 8'h3C, 1'b1);
      t = 0;
      while (!i8.out_valid && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) check("w8_bp_timeout", 64'd1, 64'd0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("w8_bp_out_valid", 64'(i8.out_valid), 64'd1);
         check("w8_bp_out_p", 64'(i8.out_p), 64'(exp));
         check("w8_bp_in_ready", 64'(i8.in_ready), 64'd0);
         check("w8_bp_busy", 64'(busy8), 64'd1);
         i8.in_valid = (k % 2 == 0);
         i8.in_a = 8'($urandom);
         i8.in_b = 8'($urandom);
      end
      i8.in_valid = 1'b0;
      i8.out_ready = 1'b1;
      @(posedge clk); #1;
      check("w8_release_out_valid", 64'(i8.out_valid), 64'd0);
      check("w8_release_in_ready", 64'(i8.in_ready), 64'd1);
      check("w8_release_busy", 64'(busy8), 64'd0);
      check("w8_bp_queue_empty", 64'(q8.size()), 64'd0);

      // Reset during the second RUN cycle abandons the operation.
      send8(8'hAB, 8'hCD, 1'b0);
      @(posedge clk); #1;
      rst8 = 1'b1;
      @(posedge clk); #1;
      check("w8_midrst_out_valid", 64'(i8.out_valid), 64'd0);
      check("w8_midrst_busy", 64'(busy8), 64'd0);
      check("w8_midrst_out_p", 64'(i8.out_p), 64'd0);
      rst8 = 1'b0;
      send8(8'h0F, 8'h0F, 1'b1);
      drain8();
   endtask

   task automatic phase4;
      i4.in_valid = 1'b0; i4.in_a = '0; i4.in_b = '0; i4.out_ready = 1'b1;
      rst4 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst4 = 1'b0;
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            send4(4'(a), 4'(b));
      drain4();
   endtask

   task automatic phase16;
      i16.in_valid = 1'b0; i16.in_a = '0; i16.in_b = '0; i16.out_ready = 1'b1;
      rst16 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst16 = 1'b0;
      fork
         begin
            for (int k = 0; k < 1000; k++) send16(16'($urandom), 16'($urandom));
            done16 = 1'b1;
         end
         begin
            while (!done16) begin
               @(posedge clk); #1;
               i16.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      i16.out_ready = 1'b1;
      drain16();
   endtask

   initial begin
      rst4 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;
      fork
         phase8();
         phase4();
         phase16();
      join
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
